// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority encoder (prio_encoder_reg).
// Provides the default width, the index-width helper and the output-register state encoding.
package prio_enc_pkg;

    localparam int DEFAULT_N = 8;

    // The index stays at least one bit wide, even for the smallest legal vector.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational rotating priority search. The request vector is rotated so that
// position 'base' lands at the top, searched by a log-depth tree, and the winning index is un-rotated.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int  N  = DEFAULT_N,
    localparam int IW = clog2_safe(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [IW-1:0] idx,
    output logic          hit
);

    localparam int P = 1 << IW;
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [N-1:0]  rot;
    logic [IW:0]   base_w;
    logic [IW-1:0] idx_rot;
    logic          hit_rot;
    logic [IW:0]   usum;
    logic [IW:0]   usel;

    assign base_w = {1'b0, base};

    // rot[k] = req[(base + k + 1) mod N]: rot[N-1] is req[base], the first position searched.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IW:0] sum;
        logic [IW:0] sel;
        assign sum = base_w + (IW+1)'(gi + 1);
        assign sel = (sum >= N_W) ? sum - N_W : sum;
        assign rot[gi] = req[sel[IW-1:0]];
    end

    // Binary reduction tree, highest index wins; padding leaves beyond N never hit.
    for (genvar gl = 0; gl <= IW; gl++) begin : g_lvl
        localparam int NODES = P >> gl;
        logic [NODES-1:0] hit_v;
        logic [IW-1:0]    idx_v [NODES];
        if (gl == 0) begin : g_leaf
            for (genvar gi = 0; gi < P; gi++) begin : g_l
                if (gi < N) begin : g_real
                    assign hit_v[gi] = rot[gi];
                end else begin : g_pad
                    assign hit_v[gi] = 1'b0;
                end
                assign idx_v[gi] = IW'(gi);
            end
        end else begin : g_node
            for (genvar gi = 0; gi < NODES; gi++) begin : g_n
                assign hit_v[gi] = g_lvl[gl-1].hit_v[2*gi+1] | g_lvl[gl-1].hit_v[2*gi];
                assign idx_v[gi] = g_lvl[gl-1].hit_v[2*gi+1] ? g_lvl[gl-1].idx_v[2*gi+1]
                                                              : g_lvl[gl-1].idx_v[2*gi];
            end
        end
    end

    assign hit_rot = g_lvl[IW].hit_v[0];
    assign idx_rot = g_lvl[IW].idx_v[0];

    // Sum is at most 2N-1, so a single conditional subtract wraps modulo N.
    assign usum = base_w + {1'b0, idx_rot} + (IW+1)'(1);
    assign usel = (usum >= N_W) ? usum - N_W : usum;

    assign hit = hit_rot;
    assign idx = hit_rot ? usel[IW-1:0] : '0;

endmodule

// File: rtl/prio_encoder_reg.sv
// Registered priority encoder with a one-entry valid/ready output register.
// Define PRIO_ENC_RR_EN for round-robin priority; otherwise the highest set index wins.
module prio_encoder_reg
    import prio_enc_pkg::*;
#(
    parameter int  N  = DEFAULT_N,
    localparam int IW = clog2_safe(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_hit,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        state_reg;
    state_t        state_next;
    logic [IW-1:0] idx_reg;
    logic          hit_reg;
    logic [IW-1:0] base;
    logic [IW-1:0] core_idx;
    logic          core_hit;
    logic          accept;

    assign out_valid = (state_reg == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_idx   = idx_reg;
    assign out_hit   = hit_reg;

`ifdef PRIO_ENC_RR_EN
    logic [IW-1:0] ptr_reg;

    // After a grant, the position just below the winner becomes highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= IW'(N - 1);
        end else if (accept && core_hit) begin
            ptr_reg <= (core_idx == '0) ? IW'(N - 1) : core_idx - IW'(1);
        end
    end

    assign base = ptr_reg;
`else
    assign base = IW'(N - 1);
`endif

    prio_enc_core #(
        .N (N)
    ) u_core (
        .req  (req_i),
        .base (base),
        .idx  (core_idx),
        .hit  (core_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            idx_reg   <= '0;
            hit_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                idx_reg <= core_idx;
                hit_reg <= core_hit;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (!accept && out_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

endmodule
